// File: rtl/crc32_fcs_ctrl_if.sv
// Byte stream bundle (data/valid/last/ready) used on both sides of the
// CRC-32 FCS sequencer: the payload input and the framed output.
interface crc32_fcs_ctrl_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc32_fcs_ctrl.sv
// crc32_fcs_ctrl: frame sequencer for a byte-wide CRC-32 engine.
// Forwards payload bytes with one cycle of latency, steps the engine on every
// accepted byte, then appends the four FCS bytes read back from the engine and
// re-initialises it, so the next frame can follow without a bubble.
// Engine pulses are only issued in cycles where the output register loads, so
// downstream backpressure simply freezes both together.
// Optional build macro CRC32_FCS_PAD_EN: short frames are zero-padded up to
// MIN_LEN payload bytes before the FCS is appended.
module crc32_fcs_ctrl #(
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 60
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc32_fcs_ctrl_if.slave      s,
    crc32_fcs_ctrl_if.master     m,
    output logic                 crc_init,
    output logic                 crc_calc,
    output logic                 crc_d_valid,
    output logic [7:0]           crc_d,
    input  logic [7:0]           crc_byte,
    output logic [CNT_W-1:0]     frame_cnt
);

`ifdef CRC32_FCS_PAD_EN
    typedef enum logic [1:0] {ST_INIT, ST_DATA, ST_FCS, ST_PAD} state_t;
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
`else
    typedef enum logic [1:0] {ST_INIT, ST_DATA, ST_FCS} state_t;
`endif

    // The byte counter must be able to represent the padding target.
    if (MIN_LEN < 1 || MIN_LEN >= (2 ** CNT_W)) begin : g_min_len_bad
        $error("crc32_fcs_ctrl: MIN_LEN does not fit in CNT_W bits");
    end

    state_t             state_q,     state_d;
    logic [7:0]         m_data_q,    m_data_d;
    logic               m_valid_q,   m_valid_d;
    logic               m_last_q,    m_last_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q,  byte_cnt_d;
    logic [1:0]         fcs_idx_q,   fcs_idx_d;

    logic               slot_free;
    logic [CNT_W-1:0]   byte_cnt_inc;

    // The output register may load whenever it is empty or being drained.
    assign slot_free    = !m_valid_q || m.ready;
    // Payload length saturates rather than wrapping on oversized frames.
    assign byte_cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;

    assign m.data    = m_data_q;
    assign m.valid   = m_valid_q;
    assign m.last    = m_last_q;
    assign frame_cnt = frame_cnt_q;

    // State and output registers; reset drops any partial frame immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
            fcs_idx_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            fcs_idx_q   <= fcs_idx_d;
        end
    end

    // Next-state, output-register loads and engine strobes.
    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        fcs_idx_d   = fcs_idx_q;
        s.ready     = 1'b0;
        crc_init    = 1'b0;
        crc_calc    = 1'b0;
        crc_d_valid = 1'b0;
        crc_d       = 8'h00;

        case (state_q)
            ST_INIT: begin
                crc_init = 1'b1;
                state_d  = ST_DATA;
            end

            ST_DATA: begin
                s.ready = slot_free;
                crc_d   = s.data;
                if (s.valid && slot_free) begin
                    crc_calc    = 1'b1;
                    crc_d_valid = 1'b1;
                    m_data_d    = s.data;
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    byte_cnt_d  = byte_cnt_inc;
                    if (s.last) begin
                        fcs_idx_d = 2'd0;
`ifdef CRC32_FCS_PAD_EN
                        state_d   = (byte_cnt_inc < MIN_LEN_C) ? ST_PAD : ST_FCS;
`else
                        state_d   = ST_FCS;
`endif
                    end
                end else if (slot_free) begin
                    m_valid_d = 1'b0;
                end
            end

`ifdef CRC32_FCS_PAD_EN
            ST_PAD: begin
                if (slot_free) begin
                    crc_calc    = 1'b1;
                    crc_d_valid = 1'b1;
                    m_data_d    = 8'h00;
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    byte_cnt_d  = byte_cnt_inc;
                    if (byte_cnt_inc >= MIN_LEN_C) begin
                        fcs_idx_d = 2'd0;
                        state_d   = ST_FCS;
                    end
                end
            end
`endif

            ST_FCS: begin
                if (slot_free) begin
                    m_data_d  = crc_byte;
                    m_valid_d = 1'b1;
                    m_last_d  = (fcs_idx_q == 2'd3);
                    if (fcs_idx_q != 2'd3) begin
                        crc_d_valid = 1'b1;
                        fcs_idx_d   = fcs_idx_q + 2'd1;
                    end else begin
                        crc_init    = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = ST_DATA;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_crc32_fcs_ctrl.sv
// Scoreboard bench for crc32_fcs_ctrl with a behavioural reflected CRC-32
// engine. Expected frames (payload, optional padding, FCS LS byte first) are
// computed from plain CRC arithmetic and queued; a monitor pops on each
// output transfer and also checks the FCS residue of every completed frame.
module tb_crc32_fcs_ctrl;
    localparam int CNT_W   = 8;
    localparam int MIN_LEN = 60;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    crc32_fcs_ctrl_if s_if ();
    crc32_fcs_ctrl_if m_if ();

    logic             crc_init, crc_calc, crc_d_valid;
    logic [7:0]       crc_d;
    logic [7:0]       crc_byte;
    logic [CNT_W-1:0] frame_cnt;

    crc32_fcs_ctrl #(.CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s           (s_if),
        .m           (m_if),
        .crc_init    (crc_init),
        .crc_calc    (crc_calc),
        .crc_d_valid (crc_d_valid),
        .crc_d       (crc_d),
        .crc_byte    (crc_byte),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed { logic [7:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] crc_reg(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < b.size(); i++) c = crc_step(c, b[i]);
        return c;
    endfunction

    // Behavioural engine: init presets, calc folds a byte in, a bare step
    // shifts the register down one byte; output shows the next FCS byte.
    logic [31:0] eng_c   = 32'hFFFF_FFFF;
    logic [7:0]  eng_out = 8'h00;
    int          dv_cnt  = 0;
    assign crc_byte = eng_out;
    always @(posedge clk) begin : engine
        logic [31:0] nc;
        if (crc_init) begin
            eng_c <= 32'hFFFF_FFFF;
        end else if (crc_d_valid) begin
            nc = crc_calc ? crc_step(eng_c, crc_d) : {8'hFF, eng_c[31:8]};
            eng_c   <= nc;
            eng_out <= ~nc[7:0];
            dv_cnt  <= dv_cnt + 1;
        end
    end

    // Downstream ready: always 1, or 50% random when rnd_ready is set.
    logic rnd_ready = 1'b0;
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    int          out_cnt = 0;
    int          cyc = 0;
    int          xfer_t[$];
    int          last_len = 0;
    logic [31:0] last_fcs = '0;
    initial begin : monitor
        logic [7:0] rx[$];
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                rx.delete();
            end else begin
                if (crc_init || crc_d_valid)
                    check("init_dv_exclusive", {31'b0, crc_init & crc_d_valid}, 32'd0);
                if (m_if.valid && m_if.ready) begin
                    out_cnt++;
                    xfer_t.push_back(cyc);
                    check("out_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", {24'b0, m_if.data}, {24'b0, e.data});
                        check("out_last", {31'b0, m_if.last}, {31'b0, e.last});
                    end
                    rx.push_back(m_if.data);
                    if (m_if.last) begin
                        last_len = rx.size();
                        if (rx.size() >= 4)
                            last_fcs = {rx[rx.size()-1], rx[rx.size()-2], rx[rx.size()-3], rx[rx.size()-4]};
                        check("frame_residue", crc_reg(rx), RESIDUE);
                        rx.delete();
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] b[$], output int len);
        logic [7:0]  p[$];
        logic [31:0] f;
        p = b;
`ifdef CRC32_FCS_PAD_EN
        while (p.size() < MIN_LEN) p.push_back(8'h00);
`endif
        f = ~crc_reg(p);
        for (int i = 0; i < p.size(); i++) exp_q.push_back(exp_t'({p[i], 1'b0}));
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_t'({f[8*k +: 8], k == 3}));
        exp_frames++;
        len = p.size() + 4;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        s_if.data  = d;
        s_if.valid = 1'b1;
        s_if.last  = l;
        n = 0;
        @(negedge clk);
        while (!s_if.ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", {31'b0, s_if.ready}, 32'd1);
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frame_cnt(input string name);
        check(name, {{(32-CNT_W){1'b0}}, frame_cnt}, exp_frames % (1 << CNT_W));
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  q[$];
        logic [7:0]  q2[$];
        logic [31:0] fcs1;
        int len, len2, base, n, dv0, wrap_n;

        s_if.valid = 1'b0;
        s_if.data  = 8'h00;
        s_if.last  = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", {31'b0, m_if.valid}, 32'd0);
        check("rst_m_data", {24'b0, m_if.data}, 32'd0);
        check("rst_m_last", {31'b0, m_if.last}, 32'd0);
        check_frame_cnt("rst_frame_cnt");
        reset_n = 1'b1;
        #1;
        check("init_after_release", {31'b0, crc_init}, 32'd1);
        @(posedge clk);
        #1;
        check("init_one_cycle", {31'b0, crc_init}, 32'd0);

        // Golden "123456789".
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        push_frame(q, len);
        send_frame(q);
        drain();
        check("t1_len", last_len, len);
`ifndef CRC32_FCS_PAD_EN
        check("t1_fcs_golden", last_fcs, 32'hCBF43926);
`endif
        fcs1 = last_fcs;
        check_frame_cnt("t1_frame_cnt");

        // 1-byte frame then 2-byte frame, back to back.
        q  = '{8'h00};
        q2 = '{8'hAA, 8'h55};
        xfer_t.delete();
        push_frame(q, len);
        push_frame(q2, len2);
        send_frame(q);
        send_frame(q2);
        drain();
        check("t2_out_count", xfer_t.size(), len + len2);
        check("t2_no_gap", xfer_t[xfer_t.size()-1] - xfer_t[0], xfer_t.size() - 1);
        check_frame_cnt("t2_frame_cnt");

        // 64-byte frame under random backpressure.
        rnd_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
        dv0 = dv_cnt;
        push_frame(q, len);
        send_frame(q);
        drain();
        check("t3_dv_pulses", dv_cnt - dv0, 67);
        check_frame_cnt("t3_frame_cnt");
        rnd_ready = 1'b0;

        // Reset while FCS byte 1 is presented.
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        push_frame(q, len);
        base = out_cnt;
        send_frame(q);
        n = 0;
        while (out_cnt - base < len - 3 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("t4_reach_fcs1", {31'b0, (out_cnt - base) >= (len - 3)}, 32'd1);
        #1;
        check("t4_fcs1_presented", {31'b0, m_if.valid}, 32'd1);
        reset_n = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        #1;
        check("t4_rst_m_valid", {31'b0, m_if.valid}, 32'd0);
        check("t4_rst_m_last", {31'b0, m_if.last}, 32'd0);
        check_frame_cnt("t4_rst_frame_cnt");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("t4_init_after_release", {31'b0, crc_init}, 32'd1);
        push_frame(q, len);
        send_frame(q);
        drain();
        check("t4_same_fcs", last_fcs, fcs1);
        check_frame_cnt("t4_frame_cnt");

        // Padding boundary: 10-byte and 61-byte frames.
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom_range(1, 255)));
        push_frame(q, len);
        send_frame(q);
        drain();
`ifdef CRC32_FCS_PAD_EN
        check("t5_len10", last_len, 64);
`else
        check("t5_len10", last_len, 14);
`endif
        q.delete();
        for (int i = 0; i < 61; i++) q.push_back(8'($urandom));
        push_frame(q, len);
        send_frame(q);
        drain();
        check("t5_len61", last_len, 65);

        // Random frames with random backpressure.
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            q.delete();
            n = $urandom_range(1, 70);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            push_frame(q, len);
            send_frame(q);
        end
        drain();
        check_frame_cnt("rand_frame_cnt");

        // Frame counter wrap.
        wrap_n = (1 << CNT_W) - (exp_frames % (1 << CNT_W));
        for (int f = 0; f < wrap_n - 1; f++) begin
            q = '{8'($urandom)};
            push_frame(q, len);
            send_frame(q);
        end
        drain();
        check("wrap_pre", {{(32-CNT_W){1'b0}}, frame_cnt}, (1 << CNT_W) - 1);
        q = '{8'($urandom)};
        push_frame(q, len);
        send_frame(q);
        drain();
        check("wrap_zero", {{(32-CNT_W){1'b0}}, frame_cnt}, 32'd0);
        rnd_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
